// File: rtl/ula_neander_n.sv
// Neander ALU: registered add/sub/logic/pass plus multi-cycle shift-add multiply,
// start/busy/done handshake and N/Z/C/V flags.
module ula_neander_n #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = WIDTH + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MULT = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NOT  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  logic [0:0]       state, state_nx;
  logic [PW-1:0]    mcand, mcand_nx;
  logic [PW-1:0]    acc, acc_nx;
  logic [WIDTH-1:0] mplier, mplier_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] result_nx;
  logic             n_nx, z_nx, c_nx, v_nx, done_nx, busy_nx;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Shared ripple adder: SUB inverts B and injects carry-in 1
  always_comb begin
    sub   = (op == OP_SUB);
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + SW'(sub);
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx  = state;
    mcand_nx  = mcand;
    acc_nx    = acc;
    mplier_nx = mplier;
    cnt_nx    = cnt;
    result_nx = result;
    n_nx      = flag_n;
    z_nx      = flag_z;
    c_nx      = flag_c;
    v_nx      = flag_v;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_nx  = {{WIDTH{1'b0}}, a};
            mplier_nx = b;
            acc_nx    = '0;
            cnt_nx    = CW'(WIDTH);
            state_nx  = MULT;
          end else if (op == OP_NOP) begin
            done_nx = 1'b1;
          end else begin
            done_nx = 1'b1;
            c_nx    = 1'b0;
            v_nx    = 1'b0;
            case (op)
              OP_ADD, OP_SUB: begin
                result_nx = sum[WIDTH-1:0];
                c_nx      = sum[WIDTH];
                v_nx      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
              end
              OP_AND:  result_nx = a & b;
              OP_OR:   result_nx = a | b;
              OP_NOT:  result_nx = ~a;
              default: result_nx = b;
            endcase
            n_nx = result_nx[WIDTH-1];
            z_nx = (result_nx == '0);
          end
        end
      end
      default: begin
        if (cnt != '0) begin
          if (mplier[0]) acc_nx = acc + mcand;
          mcand_nx  = mcand << 1;
          mplier_nx = mplier >> 1;
          cnt_nx    = cnt - CW'(1);
        end else begin
          result_nx = acc[WIDTH-1:0];
          n_nx      = acc[WIDTH-1];
          z_nx      = (acc[WIDTH-1:0] == '0);
          c_nx      = |acc[PW-1:WIDTH];
          v_nx      = |acc[PW-1:WIDTH];
          done_nx   = 1'b1;
          state_nx  = IDLE;
        end
      end
    endcase
    busy_nx = (state_nx == MULT);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b1;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      mcand  <= mcand_nx;
      acc    <= acc_nx;
      mplier <= mplier_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      flag_n <= n_nx;
      flag_z <= z_nx;
      flag_c <= c_nx;
      flag_v <= v_nx;
      done   <= done_nx;
      busy   <= busy_nx;
    end
  end

endmodule

// File: tb/tb_ula_neander_n.sv
// Directed bench for ula_neander_n at WIDTH=8 and WIDTH=3.
module tb_ula_neander_n;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       n, z, c, v;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8 = 1'b0, busy8, done8, n8, z8, c8, v8;
  logic [2:0] op8 = 3'd7;
  logic [7:0] a8 = '0, b8 = '0, res8;

  logic       s3 = 1'b0, busy3, done3, n3, z3, c3, v3;
  logic [2:0] op3 = 3'd7;
  logic [2:0] a3 = '0, b3 = '0, res3;

  int n_cmp = 0;
  int n_bad = 0;

  ula_neander_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8),
    .flag_n(n8), .flag_z(z8), .flag_c(c8), .flag_v(v8)
  );

  ula_neander_n #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3), .op(op3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .result(res3),
    .flag_n(n3), .flag_z(z3), .flag_c(c3), .flag_v(v3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // {busy,done,result,n,z,c,v} of the 8-bit instance
  function automatic logic [31:0] out8();
    return 32'({busy8, done8, res8, n8, z8, c8, v8});
  endfunction

  function automatic logic [31:0] out3();
    return 32'({busy3, done3, res3, n3, z3, c3, v3});
  endfunction

  task automatic apply8(input string nm, input vec_t t);
    @(negedge clk);
    s8 = 1'b1; op8 = t.op; a8 = t.a; b8 = t.b;
    @(posedge clk); #1;
    chk(nm, out8(), 32'({1'b0, 1'b1, t.r, t.n, t.z, t.c, t.v}));
  endtask

  task automatic mul8(input string nm, input logic [7:0] ma, input logic [7:0] mb,
                      input logic [7:0] er, input logic en, input logic ez,
                      input logic ecv, input bit intf);
    int  dones;
    bit  busy_ok;
    dones   = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    s8 = 1'b1; op8 = 3'b110; a8 = ma; b8 = mb;
    @(posedge clk); #1;
    chk({nm, " accept"}, 32'({busy8, done8}), 32'(2'b10));
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (intf) begin s8 = 1'b1; op8 = 3'b000; a8 = 8'hFF; b8 = 8'hFF; end
      else s8 = 1'b0;
      @(posedge clk); #1;
      if (done8) dones++;
      if (busy8 !== 1'b1) busy_ok = 1'b0;
    end
    chk({nm, " busy"}, 32'(busy_ok), 32'(1));
    @(negedge clk);
    s8 = 1'b0;
    @(posedge clk); #1;
    if (done8) dones++;
    chk({nm, " done"}, out8(), 32'({1'b0, 1'b1, er, en, ez, ecv, ecv}));
    @(posedge clk); #1;
    if (done8) dones++;
    chk({nm, " hold"}, out8(), 32'({1'b0, 1'b0, er, en, ez, ecv, ecv}));
    chk({nm, " dones"}, 32'(dones), 32'(1));
  endtask

  vec_t t8[12];
  vec_t t3[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dones;
    vec_t v;

    t8[0]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
    t8[1]  = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    t8[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0};
    t8[3]  = '{3'b101, 8'h33, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    t8[4]  = '{3'b111, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    t8[5]  = '{3'b010, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    t8[6]  = '{3'b011, 8'hF0, 8'h0F, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
    t8[7]  = '{3'b100, 8'h55, 8'h00, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0};
    t8[8]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    t8[9]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1};
    t8[10] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    t8[11] = '{3'b111, 8'h01, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};

    t3[0] = '{3'b001, 8'h03, 8'h05, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1};
    t3[1] = '{3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    t3[2] = '{3'b000, 8'h03, 8'h01, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1};
    t3[3] = '{3'b000, 8'h07, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    t3[4] = '{3'b000, 8'h02, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};

    #12;
    chk("reset w8", out8(), 32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    chk("reset w3", out3(), 32'({1'b0, 1'b0, 3'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops
    for (int i = 0; i < 12; i++) apply8($sformatf("w8 vec %0d", i), t8[i]);
    @(negedge clk);
    s8 = 1'b0;
    @(posedge clk); #1;
    chk("w8 done drops", out8(), 32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1}));

    mul8("mul 0f*11", 8'h0F, 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    mul8("mul 10*10 intf", 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a multiply
    v = '{3'b101, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0};
    apply8("pass 5a", v);
    @(negedge clk);
    s8 = 1'b1; op8 = 3'b110; a8 = 8'h03; b8 = 8'h03;
    @(posedge clk); #1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("mid-mul reset", out8(), 32'({1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 || busy8) dones++;
    end
    chk("no done after abort", 32'(dones), 32'(0));
    v = '{3'b000, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    apply8("add after abort", v);
    @(negedge clk);
    s8 = 1'b0;

    // Narrow instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s3 = 1'b1; op3 = t3[i].op; a3 = t3[i].a[2:0]; b3 = t3[i].b[2:0];
      @(posedge clk); #1;
      chk($sformatf("w3 vec %0d", i), out3(),
          32'({1'b0, 1'b1, t3[i].r[2:0], t3[i].n, t3[i].z, t3[i].c, t3[i].v}));
    end
    @(negedge clk);
    s3 = 1'b0;
    @(posedge clk); #1;
    chk("w3 done drops", 32'(done3), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
